clkdiv_ctrl: RTL and testbench

CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

---
 rtl/clkdiv_ctrl.sv | 133 +++++++++++++
 tb/tb_clkdiv_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_ctrl.sv
// Pixel / segment clock-enable generator with shadowed reconfiguration.
// New settings taken while running are held until the next pixel-period boundary.
//
// state | meaning
// IDLE  | enables off, counters cleared, configuration applied directly
// RUN   | generating pix_en / pix_clk / seg_en
// PEND  | new configuration held in shadow, waiting for pix_en to apply
module clkdiv_ctrl #(
  parameter int unsigned DIV_RST = 4,
  parameter int unsigned SEG_RST = 18
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       run,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_div,
  input  logic [4:0] cfg_seg,
  output logic       cfg_ready,
  output logic       cfg_err,
  output logic       pix_en,
  output logic       pix_clk,
  output logic       seg_en,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t      state, state_n;
  logic        arm;
  logic [7:0]  div_reg, div_n, sdiv, sdiv_n;
  logic [4:0]  seg_reg, seg_n, sseg, sseg_n;
  logic [7:0]  pix_cnt, pix_cnt_n;
  logic [22:0] seg_cnt, seg_cnt_n, seg_mask;
  logic        xfer, legal, busy_n, restart;
  logic [4:0]  seg_req;

  assign cfg_ready = (state != PEND);
  assign busy      = (state != IDLE);
  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = (cfg_div != 8'd0) && (cfg_seg != 5'd0);
  assign seg_req   = (cfg_seg > 5'd23) ? 5'd23 : cfg_seg;

  always_comb begin
    state_n = state;
    div_n   = div_reg;
    seg_n   = seg_reg;
    sdiv_n  = sdiv;
    sseg_n  = sseg;
    restart = 1'b0;
    case (state)
      IDLE: begin
        if (xfer && legal) begin
          div_n  = cfg_div;
          seg_n  = seg_req;
          sdiv_n = cfg_div;
          sseg_n = seg_req;
        end
        // arm keeps the first post-reset edge from starting the controller
        if (run && arm) state_n = RUN;
      end
      RUN: begin
        if (!run) begin
          state_n = IDLE;
          if (xfer && legal) begin
            div_n  = cfg_div;
            seg_n  = seg_req;
            sdiv_n = cfg_div;
            sseg_n = seg_req;
          end
        end else if (xfer && legal) begin
          sdiv_n  = cfg_div;
          sseg_n  = seg_req;
          state_n = PEND;
        end
      end
      PEND: begin
        if (!run) begin
          state_n = IDLE;
          div_n   = sdiv;
          seg_n   = sseg;
        end else if (pix_en) begin
          state_n = RUN;
          div_n   = sdiv;
          seg_n   = sseg;
          restart = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
    if (!busy_n || restart || state == IDLE) begin
      pix_cnt_n = 8'd0;
      seg_cnt_n = 23'd0;
    end else begin
      pix_cnt_n = (pix_cnt == div_reg - 8'd1) ? 8'd0 : pix_cnt + 8'd1;
      seg_cnt_n = seg_cnt + 23'd1;
    end
    // seg_n = 23 shifts out of range and wraps the mask to all ones
    seg_mask = (23'd1 << seg_n) - 23'd1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      arm     <= 1'b0;
      div_reg <= 8'(DIV_RST);
      seg_reg <= 5'(SEG_RST);
      sdiv    <= 8'(DIV_RST);
      sseg    <= 5'(SEG_RST);
      pix_cnt <= 8'd0;
      seg_cnt <= 23'd0;
      pix_en  <= 1'b0;
      pix_clk <= 1'b0;
      seg_en  <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_n;
      arm     <= 1'b1;
      div_reg <= div_n;
      seg_reg <= seg_n;
      sdiv    <= sdiv_n;
      sseg    <= sseg_n;
      pix_cnt <= pix_cnt_n;
      seg_cnt <= seg_cnt_n;
      pix_en  <= busy_n && (pix_cnt_n == div_n - 8'd1);
      pix_clk <= busy_n && (pix_cnt_n < (div_n >> 1));
      seg_en  <= busy_n && ((seg_cnt_n & seg_mask) == seg_mask);
      cfg_err <= xfer && !legal;
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: defaults, shadowed reconfig, illegal requests,
// stop/restart paths and asynchronous reset.
module tb_clkdiv_ctrl;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       run = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic [4:0] cfg_seg = 5'd0;
  logic       cfg_ready, cfg_err, pix_en, pix_clk, seg_en, busy;

  int vec = 0;
  int err = 0;

  clkdiv_ctrl dut (
    .clk(clk), .clr_n(clr_n), .run(run), .cfg_valid(cfg_valid),
    .cfg_div(cfg_div), .cfg_seg(cfg_seg), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .pix_en(pix_en), .pix_clk(pix_clk),
    .seg_en(seg_en), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // {pix_en, pix_clk, seg_en, busy, cfg_ready, cfg_err}
  function automatic logic [5:0] outs();
    return {pix_en, pix_clk, seg_en, busy, cfg_ready, cfg_err};
  endfunction

  task automatic test_reset;
    clr_n = 1'b0;
    run   = 1'b1;
    repeat (2) tick;
    vec++;
    if (outs() !== 6'b000010) begin
      err++;
      $display("FAIL reset_outputs: got %b expected %b", outs(), 6'b000010);
    end
  endtask

  task automatic test_default;
    clr_n = 1'b1;
    tick;
    vec++;
    if (busy !== 1'b0) begin
      err++;
      $display("FAIL release_edge1_busy: got %b expected 0", busy);
    end
    tick;
    vec++;
    if (busy !== 1'b1) begin
      err++;
      $display("FAIL release_edge2_busy: got %b expected 1", busy);
    end
    for (int i = 0; i < 12; i++) begin
      vec++;
      if ({pix_en, pix_clk, seg_en} !== {i % 4 == 3, i % 4 < 2, 1'b0}) begin
        err++;
        $display("FAIL default_div4 cyc %0d: got %b expected %b", i,
                 {pix_en, pix_clk, seg_en}, {i % 4 == 3, i % 4 < 2, 1'b0});
      end
      tick;
    end
  endtask

  task automatic test_reconfig;
    tick;
    cfg_valid = 1'b1; cfg_div = 8'd3; cfg_seg = 5'd18;
    vec++;
    if (cfg_ready !== 1'b1) begin
      err++;
      $display("FAIL reconfig_ready_run: got %b expected 1", cfg_ready);
    end
    tick;
    cfg_valid = 1'b0;
    vec++;
    if ({cfg_ready, busy, pix_en} !== 3'b010) begin
      err++;
      $display("FAIL reconfig_pend: got %b expected 010", {cfg_ready, busy, pix_en});
    end
    tick;
    vec++;
    if ({cfg_ready, pix_en} !== 2'b01) begin
      err++;
      $display("FAIL reconfig_apply_cycle: got %b expected 01", {cfg_ready, pix_en});
    end
    cfg_valid = 1'b1; cfg_div = 8'd5;
    tick;
    cfg_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      vec++;
      if ({pix_en, pix_clk, cfg_ready} !== {i % 3 == 2, i % 3 == 0, 1'b1}) begin
        err++;
        $display("FAIL reconfig_div3 cyc %0d: got %b expected %b", i,
                 {pix_en, pix_clk, cfg_ready}, {i % 3 == 2, i % 3 == 0, 1'b1});
      end
      tick;
    end
  endtask

  task automatic test_illegal_run;
    cfg_valid = 1'b1; cfg_div = 8'd7; cfg_seg = 5'd0;
    tick;
    cfg_valid = 1'b0;
    vec++;
    if ({cfg_err, busy, cfg_ready} !== 3'b111) begin
      err++;
      $display("FAIL illegal_run_err: got %b expected 111", {cfg_err, busy, cfg_ready});
    end
    tick;
    vec++;
    if ({cfg_err, pix_en} !== 2'b01) begin
      err++;
      $display("FAIL illegal_run_after: got %b expected 01", {cfg_err, pix_en});
    end
  endtask

  task automatic test_stop;
    run = 1'b0;
    tick;
    vec++;
    if (outs() !== 6'b000010) begin
      err++;
      $display("FAIL stop_outputs: got %b expected %b", outs(), 6'b000010);
    end
  endtask

  task automatic test_illegal_idle;
    cfg_valid = 1'b1; cfg_div = 8'd0; cfg_seg = 5'd5;
    tick;
    cfg_valid = 1'b0;
    vec++;
    if ({cfg_err, busy} !== 2'b10) begin
      err++;
      $display("FAIL illegal_idle_err: got %b expected 10", {cfg_err, busy});
    end
    tick;
    vec++;
    if (cfg_err !== 1'b0) begin
      err++;
      $display("FAIL illegal_idle_pulse_width: got %b expected 0", cfg_err);
    end
    run = 1'b1;
    tick;
    for (int i = 0; i < 6; i++) begin
      vec++;
      if ({pix_en, pix_clk} !== {i % 3 == 2, i % 3 == 0}) begin
        err++;
        $display("FAIL illegal_idle_div_kept cyc %0d: got %b expected %b", i,
                 {pix_en, pix_clk}, {i % 3 == 2, i % 3 == 0});
      end
      tick;
    end
    run = 1'b0;
    tick;
  endtask

  task automatic test_div1;
    cfg_valid = 1'b1; cfg_div = 8'd1; cfg_seg = 5'd31;
    tick;
    cfg_valid = 1'b0;
    run = 1'b1;
    tick;
    for (int i = 0; i < 8; i++) begin
      vec++;
      if ({pix_en, pix_clk, seg_en} !== 3'b100) begin
        err++;
        $display("FAIL div1 cyc %0d: got %b expected 100", i, {pix_en, pix_clk, seg_en});
      end
      tick;
    end
    run = 1'b0;
    tick;
  endtask

  task automatic test_seg;
    cfg_valid = 1'b1; cfg_div = 8'd2; cfg_seg = 5'd3;
    tick;
    cfg_valid = 1'b0;
    run = 1'b1;
    tick;
    for (int i = 0; i < 16; i++) begin
      vec++;
      if ({pix_en, pix_clk, seg_en} !== {i % 2 == 1, i % 2 == 0, i % 8 == 7}) begin
        err++;
        $display("FAIL seg3 cyc %0d: got %b expected %b", i,
                 {pix_en, pix_clk, seg_en}, {i % 2 == 1, i % 2 == 0, i % 8 == 7});
      end
      tick;
    end
  endtask

  task automatic test_pend_stop;
    tick;
    cfg_valid = 1'b1; cfg_div = 8'd5; cfg_seg = 5'd3;
    vec++;
    if ({pix_en, cfg_ready} !== 2'b11) begin
      err++;
      $display("FAIL pend_stop_setup: got %b expected 11", {pix_en, cfg_ready});
    end
    tick;
    cfg_valid = 1'b0;
    vec++;
    if ({cfg_ready, pix_en, busy} !== 3'b001) begin
      err++;
      $display("FAIL pend_stop_in_pend: got %b expected 001", {cfg_ready, pix_en, busy});
    end
    run = 1'b0;
    tick;
    vec++;
    if (outs() !== 6'b000010) begin
      err++;
      $display("FAIL pend_stop_idle: got %b expected %b", outs(), 6'b000010);
    end
    run = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) begin
      vec++;
      if ({pix_en, pix_clk, seg_en} !== {i % 5 == 4, i % 5 < 2, i % 8 == 7}) begin
        err++;
        $display("FAIL pend_stop_div5 cyc %0d: got %b expected %b", i,
                 {pix_en, pix_clk, seg_en}, {i % 5 == 4, i % 5 < 2, i % 8 == 7});
      end
      tick;
    end
  endtask

  task automatic test_async_reset;
    #3;
    clr_n = 1'b0;
    #1;
    vec++;
    if (outs() !== 6'b000010) begin
      err++;
      $display("FAIL async_reset_outputs: got %b expected %b", outs(), 6'b000010);
    end
    tick;
    clr_n = 1'b1;
    tick;
    vec++;
    if (busy !== 1'b0) begin
      err++;
      $display("FAIL async_release_edge1_busy: got %b expected 0", busy);
    end
    tick;
    for (int i = 0; i < 8; i++) begin
      vec++;
      if ({pix_en, pix_clk, busy} !== {i % 4 == 3, i % 4 < 2, 1'b1}) begin
        err++;
        $display("FAIL async_reset_div4 cyc %0d: got %b expected %b", i,
                 {pix_en, pix_clk, busy}, {i % 4 == 3, i % 4 < 2, 1'b1});
      end
      tick;
    end
  endtask

  task automatic test_run_fall_xfer;
    cfg_valid = 1'b1; cfg_div = 8'd2; cfg_seg = 5'd3;
    run = 1'b0;
    tick;
    cfg_valid = 1'b0;
    vec++;
    if ({busy, cfg_err, pix_en} !== 3'b000) begin
      err++;
      $display("FAIL run_fall_xfer_idle: got %b expected 000", {busy, cfg_err, pix_en});
    end
    run = 1'b1;
    tick;
    for (int i = 0; i < 6; i++) begin
      vec++;
      if ({pix_en, pix_clk} !== {i % 2 == 1, i % 2 == 0}) begin
        err++;
        $display("FAIL run_fall_xfer_div2 cyc %0d: got %b expected %b", i,
                 {pix_en, pix_clk}, {i % 2 == 1, i % 2 == 0});
      end
      tick;
    end
    run = 1'b0;
    tick;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_default;
    test_reconfig;
    test_illegal_run;
    test_stop;
    test_illegal_idle;
    test_div1;
    test_seg;
    test_pend_stop;
    test_async_reset;
    test_run_fall_xfer;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
